data_mem_master: RTL and testbench
==================================

// Module: data_mem_master
// PURPOSE
//  Initiator for the CPU data-memory port: accepts one load/store at a time from the core,
//  drives the memory's one-cycle request strobes, waits for the out_data_mem done pulse and
//  returns read data or store completion to the core. Sits between the execute stage and data_mem.
// PARAMETERS
//  ADDR_W          4   address width (16-word memory)
//  DATA_W          16  data word width
//  TIMEOUT_CYCLES  15  max WAIT cycles before abort (used only with DMM_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock; all logic on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  req_valid      in   1       core request valid
//  req_ready      out  1       unit can accept request (high only in IDLE with mem_done low)
//  req_we         in   1       1 = store, 0 = load
//  req_adr        in   ADDR_W  word address
//  req_wdata      in   DATA_W  store data
//  rsp_valid      out  1       one-cycle completion pulse to core
//  rsp_rdata      out  DATA_W  load data, valid with rsp_valid (held until next load)
//  rsp_err        out  1       completion was a timeout abort (0 without DMM_TIMEOUT_EN)
//  in_data_mem    out  1       read strobe to memory (one cycle)
//  write_data     out  1       write strobe to memory (one cycle)
//  adr_data       out  ADDR_W  read address to memory
//  adr_data_write out  ADDR_W  write address to memory
//  data_write     out  DATA_W  write data to memory
//  data           in   DATA_W  read data from memory
//  out_data_mem   in   1       memory done pulse
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (req_ready goes 1 on first cycle out of reset if mem done low).
//  - All outputs registered. Transfer on req_valid & req_ready at a rising edge.
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: req_ready=1 unless out_data_mem=1 (memory still clearing a previous done). On accept,
//    latch we/adr/wdata; next cycle enter ISSUE.
//  - ISSUE (1 cycle): load: in_data_mem=1, adr_data=adr. Store: write_data=1, adr_data_write=adr,
//    data_write=wdata. Exactly one strobe, exactly one cycle; never both. -> WAIT.
//  - WAIT: strobes 0, addresses/data_write held. On out_data_mem=1: load captures data into
//    rsp_rdata; -> RESP. Memory returns done one cycle after sampling the strobe, so minimum
//    accept-to-rsp_valid latency is 4 cycles.
//  - RESP: rsp_valid=1 for exactly one cycle, rsp_err per abort flag; -> IDLE. Core may not stall rsp.
//  - Store completion: rsp_valid with rsp_rdata unchanged.
//  - A done pulse seen outside WAIT is ignored (no state change, no rsp).
//  - req_valid while busy: req_ready=0, request not lost on core side (core holds it).
//  - Reset mid-operation: returns to IDLE immediately, strobes drop asynchronously; no rsp issued.
// CONFIGURATION
//  DMM_TIMEOUT_EN defined: WAIT counter (clog2(TIMEOUT_CYCLES+1) bits) cleared on entry; if it
//    reaches TIMEOUT_CYCLES with no done pulse, go to RESP with rsp_err=1, rsp_rdata unchanged.
//    Counter saturates, never wraps. Done on the same cycle as limit wins (no error).
//  DMM_TIMEOUT_EN undefined: no counter; WAIT persists until done; rsp_err tied 0.
// TESTING
//  1 load adr=2 (mem[2]=3) -> in_data_mem one cycle, adr_data=2, rsp_valid 4 cycles after accept, rsp_rdata=3.
//  2 store adr=5 wdata=16'hABCD then load adr=5 -> write_data one cycle, rsp_valid; load returns 16'hABCD.
//  3 req_valid held high across 3 back-to-back loads (adr 0,1,3) -> req_ready low while busy,
//    never accept while out_data_mem=1; results 1,2,4 in order, no strobe overlap.
//  4 rst_n low during WAIT -> all outputs 0 immediately, state IDLE, no rsp_valid after release.
//  5 DMM_TIMEOUT_EN, memory model never answers -> rsp_valid with rsp_err=1 after TIMEOUT_CYCLES=15
//    WAIT cycles; next load to responsive memory completes with rsp_err=0.
//  6 spurious out_data_mem pulse in IDLE -> no rsp_valid, req_ready low that cycle only.

Source files
------------

// File: rtl/data_mem_master.sv
// data_mem_master -- initiator for the CPU data-memory port.
//
// Accepts one load/store at a time from the core, fires a one-cycle read or
// write strobe at data_mem, waits for the memory's done pulse and returns a
// one-cycle completion (with load data) to the core.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             core request handshake
//   req_we, req_adr, req_wdata      request fields (1 = store)
//   rsp_valid, rsp_rdata, rsp_err   one-cycle completion, load data, abort flag
//   in_data_mem, adr_data           read strobe + read address to memory
//   write_data, adr_data_write,
//   data_write                      write strobe + address + data to memory
//   data, out_data_mem              read data and done pulse from memory
//
// Optional feature macro: DMM_TIMEOUT_EN
//   When defined, WAIT aborts after TIMEOUT_CYCLES cycles without a done pulse
//   and completes with rsp_err=1. When undefined, WAIT waits forever and
//   rsp_err is tied low.
module data_mem_master #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_adr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              in_data_mem,
    output logic              write_data,
    output logic [ADDR_W-1:0] adr_data,
    output logic [ADDR_W-1:0] adr_data_write,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data,
    input  logic              out_data_mem
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   ready_q;   // registered "in IDLE" flag
    logic   we_q;      // latched request type, steers data capture in WAIT
    logic   accept;

    // ready_q is registered; the done-pulse gate is applied combinationally so
    // a request is never accepted in the very cycle memory is still pulsing
    // done, and the stall lasts only that cycle.
    assign req_ready = ready_q & ~out_data_mem;
    assign accept    = req_valid & req_ready;

`ifdef DMM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ready_q        <= 1'b0;
            we_q           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            in_data_mem    <= 1'b0;
            write_data     <= 1'b0;
            adr_data       <= '0;
            adr_data_write <= '0;
            data_write     <= '0;
`ifdef DMM_TIMEOUT_EN
            wait_cnt       <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            // pulses default low; each is set for exactly one cycle below
            rsp_valid   <= 1'b0;
            in_data_mem <= 1'b0;
            write_data  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        ready_q <= 1'b0;
                        state   <= ISSUE;
                        // strobe registered here so it is high during ISSUE
                        if (req_we) begin
                            write_data     <= 1'b1;
                            adr_data_write <= req_adr;
                            data_write     <= req_wdata;
                        end else begin
                            in_data_mem <= 1'b1;
                            adr_data    <= req_adr;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef DMM_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    // done wins over a timeout landing on the same cycle
                    if (out_data_mem) begin
                        if (!we_q) rsp_rdata <= data;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef DMM_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // this is the TIMEOUT_CYCLES-th WAIT cycle with no done
                        wait_cnt  <= CNT_W'(TIMEOUT_CYCLES);
                        err_q     <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
`ifdef DMM_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_master.sv
// Scoreboard bench for data_mem_master: a driver issues requests and pushes the
// expected completion into a queue; a negedge monitor pops and compares on each
// rsp_valid and checks strobe/handshake rules continuously. Includes a simple
// 16-word memory that raises done one cycle after sampling a strobe.
module tb_data_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [3:0]  req_adr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        in_data_mem, write_data;
    logic [3:0]  adr_data, adr_data_write;
    logic [15:0] data_write;
    logic [15:0] data;
    logic        out_data_mem;

    data_mem_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .in_data_mem(in_data_mem), .write_data(write_data),
        .adr_data(adr_data), .adr_data_write(adr_data_write),
        .data_write(data_write), .data(data), .out_data_mem(out_data_mem)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [15:0] mem [16];
    logic        mem_init = 1'b0;
    logic        pend, pend_we, mem_done;
    logic [3:0]  pend_adr;
    logic        mute = 1'b0;   // memory never answers
    logic        spur = 1'b0;   // injected stray done pulse
    assign out_data_mem = mem_done | spur;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'(i + 1);
            mem_init <= 1'b1;
        end else if (write_data && !mute) begin
            mem[adr_data_write] <= data_write;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0; pend_we <= 1'b0; pend_adr <= '0;
            mem_done <= 1'b0; data <= '0;
        end else begin
            mem_done <= 1'b0;
            pend     <= 1'b0;
            if (pend) begin
                mem_done <= 1'b1;
                if (!pend_we) data <= mem[pend_adr];
            end
            if ((in_data_mem || write_data) && !mute) begin
                pend     <= 1'b1;
                pend_we  <= write_data;
                pend_adr <= write_data ? adr_data_write : adr_data;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [15:0] rdata;
        logic        err;
        int          acc;   // cycle count at the accepting edge
        int          lat;   // rising edges from accept to the edge before rsp is sampled
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_mem [16];
    logic [15:0] last_rd = '0;
    int          cyc = 0;
    int          vectors = 0;
    int          errs = 0;
    logic        prev_strobe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_data_mem && write_data) chk("strobe_overlap", 1, 0);
            if (out_data_mem && req_ready) chk("ready_during_done", 1, 0);
            if (in_data_mem || write_data) begin
                chk("strobe_one_cycle", {31'd0, prev_strobe}, 0);
                if (q.size() == 0) chk("strobe_without_req", 1, 0);
                else begin
                    chk("strobe_kind", {31'd0, write_data}, {31'd0, q[0].we});
                    chk("strobe_adr", {28'd0, write_data ? adr_data_write : adr_data},
                        {28'd0, q[0].adr});
                end
            end
            if (rsp_valid) begin
                if (q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_latency", cyc - e.acc, e.lat);
                end
            end
        end
        prev_strobe <= rst_n & (in_data_mem | write_data);
    end

    // Issue one request; returns just after the accepting rising edge.
    // Normal completion: the accepting edge is cycle 0 and rsp_valid is
    // sampled by the core at the 4th rising edge; the monitor sees it at the
    // negedge after edge 3. Timeout: 15 WAIT cycles, seen after edge 16.
    task automatic issue(input logic we, input logic [3:0] adr, input logic [15:0] wd,
                         input logic err);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wd;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 1, 0);
            req_valid = 1'b0;
            return;
        end
        e.we = we; e.adr = adr; e.err = err;
        e.acc = cyc + 1;
        e.lat = err ? 16 : 3;
        if (we) begin
            e.rdata = last_rd;
            ref_mem[adr] = wd;
        end else if (err) begin
            e.rdata = last_rd;
        end else begin
            e.rdata = ref_mem[adr];
            last_rd = ref_mem[adr];
        end
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        if (q.size() != 0) begin
            chk("rsp_missing", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'(i + 1);

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {req_ready, rsp_valid, rsp_err, in_data_mem, write_data,
                              adr_data, adr_data_write, 16'd0} ^ {16'd0, rsp_rdata | data_write}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready}, 1);

        // 1: load adr 2
        issue(1'b0, 4'd2, 16'h0, 1'b0);
        drain();

        // 2: store then load back
        issue(1'b1, 4'd5, 16'hABCD, 1'b0);
        drain();
        issue(1'b0, 4'd5, 16'h0, 1'b0);
        drain();

        // 3: back-to-back loads with req_valid held high
        issue(1'b0, 4'd0, 16'h0, 1'b0);
        issue(1'b0, 4'd1, 16'h0, 1'b0);
        issue(1'b0, 4'd3, 16'h0, 1'b0);
        drain();

        // 4: reset while in WAIT
        issue(1'b0, 4'd4, 16'h0, 1'b0);
        @(posedge clk); #1;       // now in WAIT
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_midop", {req_ready, rsp_valid, rsp_err, in_data_mem, write_data,
                            adr_data, adr_data_write, 16'd0} ^ {16'd0, rsp_rdata | data_write}, 0);
        q.delete();
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);  // monitor flags any stray rsp
        chk("ready_after_midop_reset", {31'd0, req_ready}, 1);

        // 6: spurious done pulse in IDLE
        @(negedge clk);
        spur = 1'b1; #1;
        chk("spur_ready_low", {31'd0, req_ready}, 0);
        @(negedge clk);
        spur = 1'b0; #1;
        chk("spur_ready_back", {31'd0, req_ready}, 1);
        repeat (3) @(negedge clk);

`ifdef DMM_TIMEOUT_EN
        // 5: silent memory -> abort, then a normal load
        mute = 1'b1;
        issue(1'b0, 4'd7, 16'h0, 1'b1);
        drain();
        mute = 1'b0;
        issue(1'b0, 4'd2, 16'h0, 1'b0);
        drain();
`endif

        // randomized mix
        for (int k = 0; k < 60; k++) begin
            logic        we;
            logic [3:0]  adr;
            logic [15:0] wd;
            we  = 1'($urandom_range(0, 1));
            adr = 4'($urandom_range(0, 15));
            wd  = 16'($urandom);
            issue(we, adr, wd, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1);
    end

endmodule
